// File: rtl/vp2_pkg.sv
`timescale 1ns/1ps
// vp2_pkg: opcodes, reply constants and parser state shared by the VP2 board top.
package vp2_pkg;

    localparam logic [7:0] OP_SPI      = 8'h00;
    localparam logic [7:0] OP_CS       = 8'h01;
    localparam logic [7:0] OP_OUT      = 8'h02;
    localparam logic [7:0] OP_DIV      = 8'h03;
    localparam logic [7:0] REPLY_BAD   = 8'h3F;
    localparam logic [7:0] SPI_DIV_RST = 8'd124;

    typedef enum logic [1:0] {CMD, DATA, EXEC, REPLY} parser_state_t;

    // Clocks per UART bit, rounded to nearest.
    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/vp2_uart.sv
`timescale 1ns/1ps
// vp2_uart: 8N1 receiver (2-flop synchronizer, start re-check, stop validation)
// and 10-bit-frame transmitter for the host link.
module vp2_uart #(
    parameter int BAUD_DIV = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rx,
    output logic       o_tx,
    output logic       o_rx_valid,
    output logic [7:0] o_rx_data,
    input  logic       i_tx_valid,
    input  logic [7:0] i_tx_data,
    output logic       o_tx_busy
);
    // Handshake: o_rx_valid strobes for one clock per good byte (no back-pressure);
    // a TX byte is taken on any clock where i_tx_valid is high and o_tx_busy is low.
    localparam logic [15:0] DIV_M1  = 16'(BAUD_DIV - 1);
    localparam logic [15:0] HALF_M1 = 16'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t   r_rx_state;
    rx_state_t   w_rx_next;
    logic        r_s1, r_s2, r_s3;
    logic [15:0] r_rx_cnt;
    logic [2:0]  r_rx_bit;
    logic [7:0]  r_rx_shift;
    logic        r_rx_valid;
    logic        w_bit_end;
    logic        w_half;

    logic        r_tx_busy;
    logic        r_tx_out;
    logic [8:0]  r_tx_shift;
    logic [15:0] r_tx_cnt;
    logic [3:0]  r_tx_bits;

    assign w_bit_end  = (r_rx_cnt == DIV_M1);
    assign w_half     = (r_rx_cnt == HALF_M1);
    assign o_rx_valid = r_rx_valid;
    assign o_rx_data  = r_rx_shift;
    assign o_tx       = r_tx_out;
    assign o_tx_busy  = r_tx_busy;

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            RX_IDLE:  if (r_s3 && !r_s2) w_rx_next = RX_START;
            RX_START: if (w_half) w_rx_next = r_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_bit_end && r_rx_bit == 3'd7) w_rx_next = RX_STOP;
            RX_STOP:  if (w_bit_end) w_rx_next = RX_IDLE;
            default:  w_rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1       <= 1'b1;
            r_s2       <= 1'b1;
            r_s3       <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_s1       <= i_rx;
            r_s2       <= r_s1;
            r_s3       <= r_s2;
            r_rx_state <= w_rx_next;
            r_rx_valid <= 1'b0;
            // Counter restarts on every state change and every data bit boundary.
            if (r_rx_state == RX_IDLE || r_rx_state != w_rx_next ||
                (r_rx_state == RX_DATA && w_bit_end))
                r_rx_cnt <= '0;
            else
                r_rx_cnt <= r_rx_cnt + 16'd1;
            if (r_rx_state == RX_START)
                r_rx_bit <= '0;
            if (r_rx_state == RX_DATA && w_bit_end) begin
                r_rx_shift <= {r_s2, r_rx_shift[7:1]};
                r_rx_bit   <= r_rx_bit + 3'd1;
            end
            if (r_rx_state == RX_STOP && w_bit_end && r_s2)
                r_rx_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_busy  <= 1'b0;
            r_tx_out   <= 1'b1;
            r_tx_shift <= '1;
            r_tx_cnt   <= '0;
            r_tx_bits  <= '0;
        end else if (!r_tx_busy) begin
            if (i_tx_valid) begin
                r_tx_busy  <= 1'b1;
                r_tx_out   <= 1'b0;
                r_tx_shift <= {1'b1, i_tx_data};
                r_tx_cnt   <= '0;
                r_tx_bits  <= '0;
            end
        end else if (r_tx_cnt == DIV_M1) begin
            r_tx_cnt <= '0;
            if (r_tx_bits == 4'd9) begin
                r_tx_busy <= 1'b0;
            end else begin
                r_tx_out   <= r_tx_shift[0];
                r_tx_shift <= {1'b1, r_tx_shift[8:1]};
                r_tx_bits  <= r_tx_bits + 4'd1;
            end
        end else begin
            r_tx_cnt <= r_tx_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/vp2_top.sv
`timescale 1ns/1ps
// vp2_top: VP2 board top. Decodes two-byte UART commands, drives the SD-card SPI
// port, LEDs and beeper, and answers every command with one reply byte.
module vp2_top
    import vp2_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int BAUD      = 115200,
    parameter int BEEP_HALF = 50_000
) (
    input  logic          clk,
    input  logic          SYSRESET,
    input  logic          UART_RX,
    output logic          UART_TX,
    input  logic          SD_DI,
    output logic          SD_CLK,
    output logic          SD_DO,
    output logic          SD_CS,
    output logic          led1,
    output logic          led2,
    output logic          led3,
    output logic          led4,
    output logic          led5,
    output logic          beep,
    output parser_state_t o_dbg_state
);
    localparam int BAUD_DIV = baud_div(CLK_HZ, BAUD);
    localparam int BW       = $clog2(BEEP_HALF + 1);
    localparam logic [BW-1:0] BEEP_M1 = BW'(BEEP_HALF - 1);

    parser_state_t r_state;
    parser_state_t w_next;
    logic [7:0]    r_op;
    logic [7:0]    r_reply;
    logic [7:0]    r_div;
    logic [4:0]    r_leds;
    logic          r_beep_en;
    logic          r_cs;

    logic          w_rx_valid;
    logic [7:0]    w_rx_data;
    logic          w_tx_valid;
    logic [7:0]    w_tx_data;
    logic          w_tx_busy;
    logic          w_accept;
    logic          w_spi_start;

    logic          r_spi_busy;
    logic          r_spi_clk;
    logic          r_spi_do;
    logic [7:0]    r_spi_cnt;
    logic [7:0]    r_spi_cur_div;
    logic [3:0]    r_spi_half;
    logic [7:0]    r_spi_tx;
    logic [7:0]    r_spi_rx;

    logic [BW-1:0] r_beep_cnt;
    logic          r_beep;

    vp2_uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
        .clk        (clk),
        .rst_n      (SYSRESET),
        .i_rx       (UART_RX),
        .o_tx       (UART_TX),
        .o_rx_valid (w_rx_valid),
        .o_rx_data  (w_rx_data),
        .i_tx_valid (w_tx_valid),
        .i_tx_data  (w_tx_data),
        .o_tx_busy  (w_tx_busy)
    );

    // Bytes arriving while the SPI or UART TX is busy are dropped.
    assign w_accept    = w_rx_valid && !r_spi_busy && !w_tx_busy;
    assign w_spi_start = (r_state == DATA) && w_accept && (r_op == OP_SPI);

    assign SD_CLK      = r_spi_clk;
    assign SD_DO       = r_spi_do;
    assign SD_CS       = r_cs;
    assign {led5, led4, led3, led2, led1} = r_leds;
    assign beep        = r_beep;
    assign o_dbg_state = r_state;

    always_comb begin
        w_next     = r_state;
        w_tx_valid = 1'b0;
        w_tx_data  = r_reply;
        case (r_state)
            CMD:  if (w_accept) w_next = DATA;
            DATA: if (w_accept) w_next = (r_op == OP_SPI) ? EXEC : REPLY;
            EXEC: if (!r_spi_busy) begin
                w_tx_data  = r_spi_rx;
                w_tx_valid = !w_tx_busy;
                w_next     = w_tx_busy ? REPLY : CMD;
            end
            REPLY: begin
                w_tx_valid = !w_tx_busy;
                if (!w_tx_busy) w_next = CMD;
            end
            default: w_next = CMD;
        endcase
    end

    always_ff @(posedge clk or negedge SYSRESET) begin
        if (!SYSRESET) begin
            r_state   <= CMD;
            r_op      <= '0;
            r_reply   <= '0;
            r_div     <= SPI_DIV_RST;
            r_leds    <= '0;
            r_beep_en <= 1'b0;
            r_cs      <= 1'b1;
        end else begin
            r_state <= w_next;
            if (r_state == CMD && w_accept)
                r_op <= w_rx_data;
            if (r_state == DATA && w_accept) begin
                case (r_op)
                    OP_SPI: ;
                    OP_CS: begin
                        r_cs    <= w_rx_data[0];
                        r_reply <= w_rx_data;
                    end
                    OP_OUT: begin
                        r_leds    <= w_rx_data[4:0];
                        r_beep_en <= w_rx_data[5];
                        r_reply   <= w_rx_data;
                    end
                    OP_DIV: begin
                        r_div   <= w_rx_data;
                        r_reply <= w_rx_data;
                    end
                    default: r_reply <= REPLY_BAD;
                endcase
            end
            if (r_state == EXEC && !r_spi_busy)
                r_reply <= r_spi_rx;
        end
    end

    // Mode 0 shifter: MISO captured on the rising SD_CLK, next MOSI bit on the falling one.
    always_ff @(posedge clk or negedge SYSRESET) begin
        if (!SYSRESET) begin
            r_spi_busy    <= 1'b0;
            r_spi_clk     <= 1'b0;
            r_spi_do      <= 1'b1;
            r_spi_cnt     <= '0;
            r_spi_cur_div <= SPI_DIV_RST;
            r_spi_half    <= '0;
            r_spi_tx      <= '0;
            r_spi_rx      <= '0;
        end else if (w_spi_start) begin
            r_spi_busy    <= 1'b1;
            r_spi_tx      <= w_rx_data;
            r_spi_do      <= w_rx_data[7];
            r_spi_cnt     <= '0;
            r_spi_half    <= '0;
            r_spi_cur_div <= r_div;
        end else if (r_spi_busy) begin
            if (r_spi_cnt == r_spi_cur_div) begin
                r_spi_cnt  <= '0;
                r_spi_half <= r_spi_half + 4'd1;
                r_spi_clk  <= ~r_spi_clk;
                if (!r_spi_clk) begin
                    r_spi_rx <= {r_spi_rx[6:0], SD_DI};
                end else begin
                    r_spi_tx <= {r_spi_tx[6:0], 1'b0};
                    r_spi_do <= (r_spi_half == 4'd15) ? 1'b1 : r_spi_tx[6];
                    if (r_spi_half == 4'd15) r_spi_busy <= 1'b0;
                end
            end else begin
                r_spi_cnt <= r_spi_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge SYSRESET) begin
        if (!SYSRESET) begin
            r_beep_cnt <= '0;
            r_beep     <= 1'b0;
        end else if (!r_beep_en) begin
            r_beep_cnt <= '0;
            r_beep     <= 1'b0;
        end else if (r_beep_cnt == BEEP_M1) begin
            r_beep_cnt <= '0;
            r_beep     <= ~r_beep;
        end else begin
            r_beep_cnt <= r_beep_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_vp2_top.sv
`timescale 1ns/1ps
// tb_vp2_top: randomized command stream against a behavioural model of the VP2
// command set, with UART/SPI bit-level driver and monitor tasks.
module tb_vp2_top;
  import vp2_pkg::*;

  localparam int CLK_HZ    = 100_000_000;
  localparam int BAUD      = 6_250_000;
  localparam int BD        = 16;
  localparam int BEEP_HALF = 500;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic SYSRESET = 1'b0;
  logic UART_RX = 1'b1;
  wire  SD_DI;
  wire  UART_TX, SD_CLK, SD_DO, SD_CS;
  wire  led1, led2, led3, led4, led5, beep;
  parser_state_t dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  vp2_top #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .BEEP_HALF(BEEP_HALF)) dut (
    .clk         (clk),
    .SYSRESET    (SYSRESET),
    .UART_RX     (UART_RX),
    .UART_TX     (UART_TX),
    .SD_DI       (SD_DI),
    .SD_CLK      (SD_CLK),
    .SD_DO       (SD_DO),
    .SD_CS       (SD_CS),
    .led1        (led1),
    .led2        (led2),
    .led3        (led3),
    .led4        (led4),
    .led5        (led5),
    .beep        (beep),
    .o_dbg_state (dbg_state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [4:0] m_leds;
  logic       m_beep_en;
  logic       m_cs;
  logic [7:0] m_div;

  task automatic model_reset();
    m_leds = '0; m_beep_en = 1'b0; m_cs = 1'b1; m_div = 8'd124;
  endtask

  task automatic model_cmd(input logic [7:0] op, input logic [7:0] arg,
                           input logic [7:0] card, output logic [7:0] reply);
    case (op)
      8'h00: reply = card;
      8'h01: begin m_cs = arg[0]; reply = arg; end
      8'h02: begin m_leds = arg[4:0]; m_beep_en = arg[5]; reply = arg; end
      8'h03: begin m_div = arg; reply = arg; end
      default: reply = 8'h3F;
    endcase
  endtask

  // ---------------- SPI card model / monitor ----------------
  logic [7:0] spi_card = 8'hFF;
  int         spi_base = 0;
  int         rise_n = 0;
  int         rise_t[$];
  int         fall_t[$];
  logic [7:0] spi_mosi = '0;
  int         spi_k;

  assign spi_k = rise_n - spi_base;
  assign SD_DI = (spi_k >= 0 && spi_k < 8) ? spi_card[3'(7 - spi_k)] : 1'b1;

  always @(posedge SD_CLK) begin
    rise_t.push_back(cyc);
    spi_mosi = {spi_mosi[6:0], SD_DO};
    rise_n++;
  end
  always @(negedge SD_CLK) fall_t.push_back(cyc);

  // ---------------- UART driver tasks ----------------
  task automatic uart_send(input logic [7:0] b, input logic stop_bit);
    @(negedge clk) UART_RX = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      UART_RX = b[i];
      repeat (BD) @(negedge clk);
    end
    UART_RX = stop_bit;
    repeat (BD) @(negedge clk);
    UART_RX = 1'b1;
    repeat (2 * BD) @(negedge clk);
  endtask

  task automatic uart_get(output logic [7:0] b, output bit ok, input int limit);
    int i;
    i = 0; ok = 1'b0; b = '0;
    while (!ok && i < limit) begin
      @(negedge clk);
      i++;
      if (UART_TX === 1'b0) ok = 1'b1;
    end
    if (ok) begin
      repeat (BD / 2) @(negedge clk);
      if (UART_TX !== 1'b0) ok = 1'b0;
      for (int k = 0; k < 8; k++) begin
        repeat (BD) @(negedge clk);
        b[k] = UART_TX;
      end
      repeat (BD) @(negedge clk);
      if (UART_TX !== 1'b1) ok = 1'b0;
    end
  endtask

  task automatic wait_beep_edge(output int t, output bit ok);
    logic b0;
    int i;
    b0 = beep; i = 0; ok = 1'b0;
    while (!ok && i < 2 * BEEP_HALF + 10) begin
      @(negedge clk);
      i++;
      if (beep !== b0) ok = 1'b1;
    end
    t = cyc;
  endtask

  // One command: opcode, optional bad-stop frame, operand, reply and output checks.
  task automatic do_cmd(input logic [7:0] op, input logic [7:0] arg,
                        input logic [7:0] card, input bit bad_first);
    logic [7:0] got, exp_r;
    bit ok;
    int d, lim, fb, pmin, pmax, p;
    d = int'(m_div) + 1;
    fb = fall_t.size();
    model_cmd(op, arg, card, exp_r);
    exp_q.push_back(exp_r);
    if (op == OP_SPI) begin
      spi_card = card;
      spi_base = rise_n;
    end
    lim = 20 * BD + 16 * d + 200;
    uart_send(op, 1'b1);
    if (bad_first) begin
      uart_send(8'($urandom), 1'b0);
      uart_get(got, ok, 30 * BD);
      check_eq("frame_err_silent", 32'(ok), 0);
      check_eq("frame_err_state", 32'(dbg_state), 32'(DATA));
    end
    fork
      uart_send(arg, 1'b1);
      uart_get(got, ok, lim);
    join
    exp_r = exp_q.pop_front();
    check_eq("reply_seen", 32'(ok), 1);
    if (ok) check_eq("reply", got, exp_r);
    repeat (2) @(negedge clk);
    check_eq("leds", {led5, led4, led3, led2, led1}, m_leds);
    check_eq("sd_cs", SD_CS, m_cs);
    if (!m_beep_en) check_eq("beep_off", beep, 0);
    check_eq("state_cmd", 32'(dbg_state), 32'(CMD));
    if (op == OP_SPI) begin
      check_eq("spi_pulses", rise_n - spi_base, 8);
      check_eq("spi_mosi", spi_mosi, arg);
      check_eq("spi_idle", {SD_CLK, SD_DO}, 2'b01);
      if (rise_n - spi_base == 8 && fall_t.size() - fb >= 8) begin
        pmin = 1 << 30; pmax = 0;
        for (int i = spi_base + 1; i < spi_base + 8; i++) begin
          p = rise_t[i] - rise_t[i-1];
          if (p < pmin) pmin = p;
          if (p > pmax) pmax = p;
        end
        check_eq("spi_period_min", pmin, 2 * d);
        check_eq("spi_period_max", pmax, 2 * d);
        // First rise is one half-period into the transfer, last fall ends it.
        check_eq("spi_length", fall_t[fall_t.size()-1] - rise_t[spi_base], 15 * d);
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lows, t0, t1, t2, i;
    bit ok0, ok1, ok2, seen;
    logic [7:0] op, arg;
    model_reset();

    #500;
    check_eq("reset_outs", {UART_TX, SD_CS, SD_CLK, SD_DO, led5, led4, led3, led2, led1, beep},
             10'b1101000000);
    check_eq("reset_state", 32'(dbg_state), 32'(CMD));
    @(negedge clk) SYSRESET = 1'b1;
    lows = 0;
    repeat (200) begin
      @(negedge clk);
      if (UART_TX !== 1'b1 || SD_CLK !== 1'b0 || SD_CS !== 1'b1 || SD_DO !== 1'b1 || beep !== 1'b0)
        lows++;
    end
    check_eq("idle_quiet", lows, 0);

    do_cmd(OP_OUT, 8'h15, 8'h00, 0);
    check_eq("leds_15", {led5, led4, led3, led2, led1}, 5'b10101);
    do_cmd(OP_CS, 8'h00, 8'h00, 0);
    do_cmd(OP_SPI, 8'hA5, 8'h3C, 0);

    // Asynchronous reset in the middle of a transfer.
    do_cmd(OP_OUT, 8'h1F, 8'h00, 0);
    spi_card = 8'h81;
    spi_base = rise_n;
    uart_send(OP_SPI, 1'b1);
    uart_send(8'h5A, 1'b1);
    seen = 1'b0; i = 0;
    while (!seen && i < 4000) begin
      @(negedge clk);
      i++;
      if (SD_CLK === 1'b1) seen = 1'b1;
    end
    check_eq("spi_active", 32'(seen), 1);
    #2 SYSRESET = 1'b0;
    #1;
    check_eq("async_reset_outs", {UART_TX, SD_CS, SD_CLK, SD_DO, led5, led4, led3, led2, led1, beep},
             10'b1101000000);
    check_eq("async_reset_state", 32'(dbg_state), 32'(CMD));
    repeat (3) @(negedge clk);
    SYSRESET = 1'b1;
    model_reset();
    repeat (4 * BD) @(negedge clk);

    do_cmd(OP_DIV, 8'h01, 8'h00, 0);
    do_cmd(OP_SPI, 8'hFF, 8'($urandom), 0);

    do_cmd(OP_OUT, 8'h20, 8'h00, 0);
    wait_beep_edge(t0, ok0);
    wait_beep_edge(t1, ok1);
    wait_beep_edge(t2, ok2);
    check_eq("beep_edges", {ok0, ok1, ok2}, 3'b111);
    check_eq("beep_half1", t1 - t0, BEEP_HALF);
    check_eq("beep_half2", t2 - t1, BEEP_HALF);
    do_cmd(OP_OUT, 8'h00, 8'h00, 0);

    do_cmd(8'h7E, 8'h55, 8'h00, 0);
    do_cmd(OP_OUT, 8'h0A, 8'h00, 1);

    for (int n = 0; n < 16; n++) begin
      i = int'($urandom_range(0, 4));
      op = (i == 4) ? 8'($urandom_range(4, 255)) : 8'(i);
      arg = (op == OP_DIV) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      do_cmd(op, arg, 8'($urandom), ($urandom_range(0, 5) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule
